// File: rtl/pipeline_memory.sv
// pipeline_memory
// RV32I memory-access stage: EX/MEM pipeline register plus a load/store unit.
// The execute-stage results are captured here. The unit drives a req/gnt/rvalid
// data-memory port with byte strobes, aligns and extends load data, and holds
// the front of the pipeline while an access is outstanding.
//
// Ports:
//   i_clk, i_rstn         clock (rising edge), asynchronous active-low reset
//   i_flush               insert a bubble into EX/MEM (ignored while stalled)
//   *E inputs             execute-stage control and data
//   o_stall               freeze IF/ID/EX and hold this stage
//   o_mem_fault           the memop in M is misaligned or has an illegal funct3
//   *M outputs            feed the MEM/WB register directly
//   o_dmem_*              request side of the data-memory port
//   i_dmem_*              grant, read-valid and read data from data memory
module pipeline_memory (
  input  logic        i_clk,
  input  logic        i_rstn,
  input  logic        i_flush,
  input  logic        RegWriteE,
  input  logic [1:0]  ResultSrcE,
  input  logic        MemWriteE,
  input  logic [2:0]  funct3E,
  input  logic [31:0] ALUResultE,
  input  logic [31:0] WriteDataE,
  input  logic [31:0] PCPlus4E,
  input  logic [4:0]  RdE,
  output logic        o_stall,
  output logic        o_mem_fault,
  output logic        RegWriteM,
  output logic [1:0]  ResultSrcM,
  output logic [31:0] ALUResultM,
  output logic [31:0] ReadDataM,
  output logic [31:0] PCPlus4M,
  output logic [4:0]  RdM,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_be,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_gnt,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT_RD = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Misalignment and illegal-funct3 detection.
  function automatic logic access_fault(input logic is_store, input logic [2:0] f3,
                                        input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    if (is_store) begin
      case (f3)
        3'b000:  bad = 1'b0;
        3'b001:  bad = lo[0];
        3'b010:  bad = (lo != 2'b00);
        default: bad = 1'b1;
      endcase
    end else begin
      case (f3)
        3'b000, 3'b100: bad = 1'b0;
        3'b001, 3'b101: bad = lo[0];
        3'b010:         bad = (lo != 2'b00);
        default:        bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

  // Byte strobes for a store of the given size at the given byte offset.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] be;
    case (f3)
      3'b000:  be = 4'b0001 << lo;
      3'b001:  be = 4'b0011 << {lo[1], 1'b0};
      3'b010:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate store data across lanes so the strobes alone select the bytes.
  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] w;
    case (f3)
      3'b000:  w = {4{d[7:0]}};
      3'b001:  w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Shift the addressed bytes down to bit 0 and sign- or zero-extend.
  function automatic logic [31:0] load_format(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [1:0] lo);
    logic [31:0] s;
    logic [31:0] r;
    s = word >> {lo, 3'b000};
    case (f3)
      3'b000:  r = {{24{s[7]}}, s[7:0]};
      3'b001:  r = {{16{s[15]}}, s[15:0]};
      3'b010:  r = s;
      3'b100:  r = {24'd0, s[7:0]};
      3'b101:  r = {16'd0, s[15:0]};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  logic        regwrite_r;
  logic [1:0]  resultsrc_r;
  logic        memwrite_r;
  logic [2:0]  funct3_r;
  logic [31:0] aluresult_r;
  logic [31:0] wdata_r;
  logic [31:0] pcplus4_r;
  logic [4:0]  rd_r;
  logic [31:0] ldbuf_r;
  state_t      state_r;
  state_t      state_s;
  logic        memop_s;
  logic        fault_s;
  logic        access_s;
  logic        req_s;

  // EX/MEM pipeline register: capture, bubble on flush, hold while stalled.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      regwrite_r  <= 1'b0;
      resultsrc_r <= 2'b00;
      memwrite_r  <= 1'b0;
      funct3_r    <= 3'b000;
      aluresult_r <= 32'd0;
      wdata_r     <= 32'd0;
      pcplus4_r   <= 32'd0;
      rd_r        <= 5'd0;
    end else if (!o_stall) begin
      if (i_flush) begin
        regwrite_r  <= 1'b0;
        resultsrc_r <= 2'b00;
        memwrite_r  <= 1'b0;
        funct3_r    <= 3'b000;
        aluresult_r <= 32'd0;
        wdata_r     <= 32'd0;
        pcplus4_r   <= 32'd0;
        rd_r        <= 5'd0;
      end else begin
        regwrite_r  <= RegWriteE;
        resultsrc_r <= ResultSrcE;
        memwrite_r  <= MemWriteE;
        funct3_r    <= funct3E;
        aluresult_r <= ALUResultE;
        wdata_r     <= WriteDataE;
        pcplus4_r   <= PCPlus4E;
        rd_r        <= RdE;
      end
    end
  end

  // Load buffer: holds the returned word from rvalid until the load retires.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      ldbuf_r <= 32'd0;
    end else if (state_r == WAIT_RD && i_dmem_rvalid) begin
      ldbuf_r <= i_dmem_rdata;
    end
  end

  // Access FSM state register.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Memop classification; a faulting memop never reaches the memory port.
  always_comb begin
    memop_s  = memwrite_r | (resultsrc_r == 2'b01);
    fault_s  = memop_s & access_fault(memwrite_r, funct3_r, aluresult_r[1:0]);
    access_s = memop_s & ~fault_s;
  end

  // Access FSM next state and request; REQ keeps asking until granted.
  always_comb begin
    state_s = state_r;
    req_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (access_s) begin
          req_s = 1'b1;
          if (i_dmem_gnt) begin
            state_s = memwrite_r ? DONE : WAIT_RD;
          end else begin
            state_s = REQ;
          end
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        req_s = 1'b1;
        if (i_dmem_gnt) begin
          state_s = memwrite_r ? DONE : WAIT_RD;
        end else begin
          state_s = REQ;
        end
      end
      WAIT_RD: begin
        if (i_dmem_rvalid) begin
          state_s = DONE;
        end else begin
          state_s = WAIT_RD;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Stage outputs. RegWriteM is gated so MEM/WB, which has no enable, sees
  // exactly one write per instruction and none for a faulting access.
  always_comb begin
    o_stall      = access_s & (state_r != DONE);
    o_mem_fault  = fault_s;
    RegWriteM    = regwrite_r & ~o_stall & ~fault_s;
    ResultSrcM   = resultsrc_r;
    ALUResultM   = aluresult_r;
    PCPlus4M     = pcplus4_r;
    RdM          = rd_r;
    o_dmem_req   = req_s;
    o_dmem_we    = memwrite_r;
    o_dmem_addr  = {aluresult_r[31:2], 2'b00};
    o_dmem_wdata = store_data(funct3_r, wdata_r);
    if (memwrite_r) begin
      o_dmem_be = store_be(funct3_r, aluresult_r[1:0]);
    end else begin
      o_dmem_be = 4'b1111;
    end
    if (resultsrc_r == 2'b01) begin
      ReadDataM = load_format(ldbuf_r, funct3_r, aluresult_r[1:0]);
    end else begin
      ReadDataM = 32'd0;
    end
  end

endmodule

// File: tb/tb_pipeline_memory.sv
module tb_pipeline_memory;

  logic        i_clk;
  logic        i_rstn;
  logic        i_flush;
  logic        RegWriteE;
  logic [1:0]  ResultSrcE;
  logic        MemWriteE;
  logic [2:0]  funct3E;
  logic [31:0] ALUResultE;
  logic [31:0] WriteDataE;
  logic [31:0] PCPlus4E;
  logic [4:0]  RdE;
  logic        o_stall;
  logic        o_mem_fault;
  logic        RegWriteM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUResultM;
  logic [31:0] ReadDataM;
  logic [31:0] PCPlus4M;
  logic [4:0]  RdM;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic [31:0] o_dmem_addr;
  logic [3:0]  o_dmem_be;
  logic [31:0] o_dmem_wdata;
  logic        i_dmem_gnt;
  logic        i_dmem_rvalid;
  logic [31:0] i_dmem_rdata;

  pipeline_memory dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_flush(i_flush),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .funct3E(funct3E), .ALUResultE(ALUResultE), .WriteDataE(WriteDataE),
    .PCPlus4E(PCPlus4E), .RdE(RdE),
    .o_stall(o_stall), .o_mem_fault(o_mem_fault), .RegWriteM(RegWriteM),
    .ResultSrcM(ResultSrcM), .ALUResultM(ALUResultM), .ReadDataM(ReadDataM),
    .PCPlus4M(PCPlus4M), .RdM(RdM),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_be(o_dmem_be), .o_dmem_wdata(o_dmem_wdata),
    .i_dmem_gnt(i_dmem_gnt), .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] val;
  } wb_t;

  wb_t exp_q[$];
  wb_t e;
  int total = 0;
  int bad = 0;

  // results of the last run_mem call
  int          r_stalls, r_req_cycles, r_first_req, r_wb_count;
  logic        r_we, r_stable, r_fault, r_timeout;
  logic [31:0] r_addr, r_wdata, r_wb_val;
  logic [3:0]  r_be;
  logic [4:0]  r_wb_rd;

  task automatic drive_e(input logic rw, input logic [1:0] rs, input logic mw,
                         input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [31:0] pc4, input logic [4:0] rd);
    RegWriteE = rw; ResultSrcE = rs; MemWriteE = mw; funct3E = f3;
    ALUResultE = alu; WriteDataE = wd; PCPlus4E = pc4; RdE = rd;
  endtask

  // Called at a negedge with an instruction in E: moves it into M.
  task automatic issue(input logic rw, input logic [1:0] rs, input logic mw,
                       input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [31:0] pc4, input logic [4:0] rd);
    drive_e(rw, rs, mw, f3, alu, wd, pc4, rd);
    @(negedge i_clk);
    drive_e(1'b0, 2'b00, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 5'd0);
  endtask

  // Memory responder: grants on the (gnt_delay+1)-th request cycle, returns
  // read data rv_delay cycles after the grant. Records what it observes until
  // the stage stops stalling. Bounded by a cycle budget.
  task automatic run_mem(input int gnt_delay, input int rv_delay,
                         input logic [31:0] rdata, input logic flush_in_stall);
    int gnt_cycle;
    bit done;
    gnt_cycle = -1; done = 1'b0;
    r_stalls = 0; r_req_cycles = 0; r_first_req = -1; r_wb_count = 0;
    r_we = 1'bx; r_addr = 32'hx; r_be = 4'hx; r_wdata = 32'hx;
    r_stable = 1'b1; r_fault = 1'b0; r_timeout = 1'b1;
    r_wb_rd = 5'hx; r_wb_val = 32'hx;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) @(negedge i_clk);
      if (o_mem_fault) r_fault = 1'b1;
      if (RegWriteM) begin
        r_wb_count++;
        r_wb_rd = RdM;
        case (ResultSrcM)
          2'b01:   r_wb_val = ReadDataM;
          2'b10:   r_wb_val = PCPlus4M;
          default: r_wb_val = ALUResultM;
        endcase
      end
      if (o_dmem_req) begin
        if (r_req_cycles == 0) begin
          r_first_req = c; r_we = o_dmem_we; r_addr = o_dmem_addr;
          r_be = o_dmem_be; r_wdata = o_dmem_wdata;
        end else if ({r_we, r_addr, r_be, r_wdata} !== {o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata}) begin
          r_stable = 1'b0;
        end
        r_req_cycles++;
      end
      i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = 32'hDEADBEEF;
      if (o_stall) begin
        r_stalls++;
        i_flush = flush_in_stall;
        if (o_dmem_req && r_req_cycles == gnt_delay + 1) begin
          i_dmem_gnt = 1'b1; gnt_cycle = c;
        end
        if (gnt_cycle >= 0 && c != gnt_cycle && c == gnt_cycle + rv_delay) begin
          i_dmem_rvalid = 1'b1; i_dmem_rdata = rdata;
        end
      end else begin
        i_flush = 1'b0; done = 1'b1; r_timeout = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    i_rstn = 1'b0; i_flush = 1'b0;
    i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = 32'd0;
    drive_e(1'b1, 2'b01, 1'b1, 3'b010, 32'h12345678, 32'h9ABCDEF0, 32'h44, 5'd31);
    repeat (2) @(negedge i_clk);
    total++;
    if ({o_stall, o_mem_fault, RegWriteM, o_dmem_req} !== 4'b0000) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0000", {o_stall, o_mem_fault, RegWriteM, o_dmem_req});
    end
    total++;
    if ({ResultSrcM, ALUResultM, ReadDataM, PCPlus4M, RdM} !== 103'd0) begin
      bad++; $display("FAIL reset_data: got alu=%h rd=%h pc4=%h rdm=%h", ALUResultM, ReadDataM, PCPlus4M, RdM);
    end
    drive_e(1'b0, 2'b00, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0, 5'd0);
    i_rstn = 1'b1;
    @(negedge i_clk);
  endtask

  task automatic test_alu;
    exp_q.push_back('{rd: 5'd5, val: 32'h1234});
    issue(1'b1, 2'b00, 1'b0, 3'b000, 32'h1234, 32'd0, 32'h80, 5'd5);
    run_mem(0, 0, 32'd0, 1'b0);
    total++;
    if (r_stalls != 0 || r_req_cycles != 0 || r_wb_count != 1) begin
      bad++; $display("FAIL alu_timing: stalls=%0d reqs=%0d wbs=%0d want 0 0 1", r_stalls, r_req_cycles, r_wb_count);
    end
    e = exp_q.pop_front(); total++;
    if (r_wb_rd !== e.rd || r_wb_val !== e.val) begin
      bad++; $display("FAIL alu_wb: got rd=%0d val=%h want rd=%0d val=%h", r_wb_rd, r_wb_val, e.rd, e.val);
    end
    // jump-and-link style result: PC+4 written back
    exp_q.push_back('{rd: 5'd1, val: 32'h20000004});
    issue(1'b1, 2'b10, 1'b0, 3'b000, 32'h77, 32'd0, 32'h20000004, 5'd1);
    run_mem(0, 0, 32'd0, 1'b0);
    e = exp_q.pop_front(); total++;
    if (r_wb_count != 1 || r_wb_rd !== e.rd || r_wb_val !== e.val) begin
      bad++; $display("FAIL pc4_wb: got n=%0d rd=%0d val=%h want rd=%0d val=%h", r_wb_count, r_wb_rd, r_wb_val, e.rd, e.val);
    end
    // flush when not stalled inserts a bubble
    i_flush = 1'b1;
    issue(1'b1, 2'b00, 1'b0, 3'b000, 32'h55, 32'd0, 32'h10, 5'd6);
    i_flush = 1'b0;
    total++;
    if ({RegWriteM, ALUResultM, RdM, PCPlus4M} !== 70'd0) begin
      bad++; $display("FAIL flush_bubble: got we=%b alu=%h rd=%0d want 0", RegWriteM, ALUResultM, RdM);
    end
  endtask

  task automatic test_store;
    issue(1'b0, 2'b00, 1'b1, 3'b000, 32'h103, 32'h000000AB, 32'd0, 5'd0);
    run_mem(0, 0, 32'd0, 1'b0);
    total++;
    if (r_stalls != 1 || r_wb_count != 0 || r_timeout) begin
      bad++; $display("FAIL sb_timing: stalls=%0d wbs=%0d to=%b want 1 0 0", r_stalls, r_wb_count, r_timeout);
    end
    total++;
    if ({r_we, r_addr, r_be, r_wdata} !== {1'b1, 32'h100, 4'b1000, 32'hABABABAB}) begin
      bad++; $display("FAIL sb_port: got we=%b addr=%h be=%b wd=%h want 1 100 1000 ababab", r_we, r_addr, r_be, r_wdata);
    end
    issue(1'b0, 2'b00, 1'b1, 3'b001, 32'h106, 32'h1234BEEF, 32'd0, 5'd0);
    run_mem(1, 0, 32'd0, 1'b0);
    total++;
    if (r_stalls != 2 || r_req_cycles != 2 || !r_stable) begin
      bad++; $display("FAIL sh_timing: stalls=%0d reqs=%0d stable=%b want 2 2 1", r_stalls, r_req_cycles, r_stable);
    end
    total++;
    if ({r_addr, r_be, r_wdata} !== {32'h104, 4'b1100, 32'hBEEFBEEF}) begin
      bad++; $display("FAIL sh_port: got addr=%h be=%b wd=%h want 104 1100 beefbeef", r_addr, r_be, r_wdata);
    end
  endtask

  task automatic test_load_wait;
    exp_q.push_back('{rd: 5'd10, val: 32'hFFFF8001});
    issue(1'b1, 2'b01, 1'b0, 3'b001, 32'h202, 32'd0, 32'd0, 5'd10);
    run_mem(2, 3, 32'h80010000, 1'b0);
    total++;
    if (r_stalls != 6 || r_wb_count != 1 || !r_stable || r_timeout) begin
      bad++; $display("FAIL lh_timing: stalls=%0d wbs=%0d stable=%b to=%b want 6 1 1 0", r_stalls, r_wb_count, r_stable, r_timeout);
    end
    total++;
    if ({r_we, r_addr, r_be} !== {1'b0, 32'h200, 4'b1111}) begin
      bad++; $display("FAIL lh_port: got we=%b addr=%h be=%b want 0 200 1111", r_we, r_addr, r_be);
    end
    e = exp_q.pop_front(); total++;
    if (r_wb_rd !== e.rd || r_wb_val !== e.val) begin
      bad++; $display("FAIL lh_wb: got rd=%0d val=%h want rd=%0d val=%h", r_wb_rd, r_wb_val, e.rd, e.val);
    end
  endtask

  task automatic test_lbu_fault;
    exp_q.push_back('{rd: 5'd11, val: 32'h00000080});
    issue(1'b1, 2'b01, 1'b0, 3'b100, 32'h3, 32'd0, 32'd0, 5'd11);
    run_mem(0, 1, 32'h80ABCDEF, 1'b0);
    e = exp_q.pop_front(); total++;
    if (r_stalls != 2 || r_wb_count != 1 || r_wb_rd !== e.rd || r_wb_val !== e.val) begin
      bad++; $display("FAIL lbu_wb: stalls=%0d n=%0d val=%h want 2 1 %h", r_stalls, r_wb_count, r_wb_val, e.val);
    end
    exp_q.push_back('{rd: 5'd13, val: 32'hFFFFCDEF});
    issue(1'b1, 2'b01, 1'b0, 3'b001, 32'h0, 32'd0, 32'd0, 5'd13);
    run_mem(0, 1, 32'h80ABCDEF, 1'b0);
    e = exp_q.pop_front(); total++;
    if (r_wb_count != 1 || r_wb_val !== e.val) begin
      bad++; $display("FAIL lh0_wb: n=%0d val=%h want 1 %h", r_wb_count, r_wb_val, e.val);
    end
    issue(1'b1, 2'b01, 1'b0, 3'b010, 32'h6, 32'd0, 32'd0, 5'd12);
    run_mem(0, 0, 32'd0, 1'b0);
    total++;
    if (!r_fault || r_req_cycles != 0 || r_stalls != 0 || r_wb_count != 0) begin
      bad++; $display("FAIL lw_misalign: fault=%b reqs=%0d stalls=%0d wbs=%0d want 1 0 0 0", r_fault, r_req_cycles, r_stalls, r_wb_count);
    end
    issue(1'b0, 2'b00, 1'b1, 3'b011, 32'h8, 32'h5, 32'd0, 5'd0);
    run_mem(0, 0, 32'd0, 1'b0);
    total++;
    if (!r_fault || r_req_cycles != 0 || r_stalls != 0) begin
      bad++; $display("FAIL st_illegal: fault=%b reqs=%0d stalls=%0d want 1 0 0", r_fault, r_req_cycles, r_stalls);
    end
  endtask

  task automatic test_flush_during_load;
    exp_q.push_back('{rd: 5'd7, val: 32'hCAFEF00D});
    issue(1'b1, 2'b01, 1'b0, 3'b010, 32'h10, 32'd0, 32'd0, 5'd7);
    run_mem(1, 2, 32'hCAFEF00D, 1'b1);
    total++;
    if (r_stalls != 4 || r_fault) begin
      bad++; $display("FAIL flush_ld_timing: stalls=%0d fault=%b want 4 0", r_stalls, r_fault);
    end
    e = exp_q.pop_front(); total++;
    if (r_wb_count != 1 || r_wb_rd !== e.rd || r_wb_val !== e.val) begin
      bad++; $display("FAIL flush_ld_wb: n=%0d rd=%0d val=%h want 1 %0d %h", r_wb_count, r_wb_rd, r_wb_val, e.rd, e.val);
    end
  endtask

  task automatic test_back_to_back;
    issue(1'b0, 2'b00, 1'b1, 3'b010, 32'h20, 32'h11223344, 32'd0, 5'd0);
    run_mem(0, 0, 32'd0, 1'b0);
    total++;
    if ({r_addr, r_be, r_wdata} !== {32'h20, 4'b1111, 32'h11223344} || r_stalls != 1) begin
      bad++; $display("FAIL sw_port: addr=%h be=%b wd=%h stalls=%0d want 20 1111 11223344 1", r_addr, r_be, r_wdata, r_stalls);
    end
    exp_q.push_back('{rd: 5'd9, val: 32'hFFFFFFF2});
    issue(1'b1, 2'b01, 1'b0, 3'b000, 32'h21, 32'd0, 32'd0, 5'd9);
    run_mem(0, 1, 32'h0000F200, 1'b0);
    total++;
    if (r_first_req != 0 || r_stalls != 2) begin
      bad++; $display("FAIL b2b_timing: first_req=%0d stalls=%0d want 0 2", r_first_req, r_stalls);
    end
    e = exp_q.pop_front(); total++;
    if (r_wb_count != 1 || r_wb_rd !== e.rd || r_wb_val !== e.val) begin
      bad++; $display("FAIL b2b_wb: n=%0d rd=%0d val=%h want 1 %0d %h", r_wb_count, r_wb_rd, r_wb_val, e.rd, e.val);
    end
  endtask

  task automatic test_reset_mid;
    issue(1'b1, 2'b01, 1'b0, 3'b010, 32'h40, 32'd0, 32'h99, 5'd3);
    i_dmem_gnt = 1'b1;
    @(negedge i_clk);
    i_dmem_gnt = 1'b0;
    total++;
    if ({o_stall, o_dmem_req} !== 2'b10) begin
      bad++; $display("FAIL wait_rd_state: stall/req=%b want 10", {o_stall, o_dmem_req});
    end
    i_rstn = 1'b0;
    #1;
    total++;
    if ({o_stall, o_mem_fault, RegWriteM, o_dmem_req, ResultSrcM, ALUResultM, ReadDataM, PCPlus4M, RdM} !== 107'd0) begin
      bad++; $display("FAIL reset_mid: stall=%b req=%b alu=%h pc4=%h rd=%0d want 0", o_stall, o_dmem_req, ALUResultM, PCPlus4M, RdM);
    end
    @(negedge i_clk);
    i_rstn = 1'b1;
    exp_q.push_back('{rd: 5'd4, val: 32'hA5A5});
    issue(1'b1, 2'b00, 1'b0, 3'b000, 32'hA5A5, 32'd0, 32'd0, 5'd4);
    run_mem(0, 0, 32'd0, 1'b0);
    e = exp_q.pop_front(); total++;
    if (r_stalls != 0 || r_wb_count != 1 || r_wb_val !== e.val) begin
      bad++; $display("FAIL post_reset_alu: stalls=%0d n=%0d val=%h want 0 1 %h", r_stalls, r_wb_count, r_wb_val, e.val);
    end
  endtask

  initial begin
    test_reset;
    test_alu;
    test_store;
    test_load_wait;
    test_lbu_fault;
    test_flush_during_load;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_memory.md
# pipeline_memory

RV32I pipelined-core memory-access stage: EX/MEM pipeline register plus load/store unit. Captures execute-stage results, drives a req/gnt/rvalid data-memory port with byte strobes, aligns and sign-extends load data, and stalls the pipeline while an access is outstanding. Its M-suffixed outputs feed the MEM/WB register directly.

## Interface
- No parameters; datapath fixed at 32 bits.
- i_clk  in  1  clock, rising edge
- i_rstn  in  1  reset, asynchronous, active-low
- i_flush  in  1  load bubble into EX/MEM register (ignored while o_stall=1)
- RegWriteE  in  1  register write enable from EX
- ResultSrcE  in  2  00 ALU, 01 load data, 10 PC+4; 01 marks a load
- MemWriteE  in  1  store
- funct3E  in  3  load/store size and sign
- ALUResultE  in  32  effective address / ALU result
- WriteDataE  in  32  store data (rs2)
- PCPlus4E  in  32  PC+4
- RdE  in  5  destination register
- o_stall  out  1  freeze IF/ID/EX; hold this stage
- o_mem_fault  out  1  misaligned or illegal-funct3 access in M
- RegWriteM  out  1  gated write enable to MEM/WB
- ResultSrcM  out  2  registered ResultSrcE
- ALUResultM  out  32  registered ALUResultE
- ReadDataM  out  32  aligned, extended load data
- PCPlus4M  out  32  registered PCPlus4E
- RdM  out  5  registered RdE
- o_dmem_req  out  1  access request
- o_dmem_we  out  1  1 store, 0 load
- o_dmem_addr  out  32  {ALUResultM[31:2], 2'b00}
- o_dmem_be  out  4  byte strobes
- o_dmem_wdata  out  32  lane-replicated store data
- i_dmem_gnt  in  1  request accepted this cycle
- i_dmem_rvalid  in  1  load data valid this cycle
- i_dmem_rdata  in  32  load word

## Operation
- EX/MEM register: o_stall=0 and i_flush=0 -> capture all E inputs; o_stall=0 and i_flush=1 -> RegWrite=0, MemWrite=0, ResultSrc=00, others 0; o_stall=1 -> hold.
- memop = MemWrite_q | (ResultSrc_q==01). Fault: SH/LH/LHU with addr[0]=1; SW/LW with addr[1:0]!=0; store funct3 not in {000,001,010}; load funct3 not in {000,001,010,100,101}. Faulting memop: no request, no stall, o_mem_fault=1 while in M, RegWriteM=0.
- FSM states IDLE, REQ, WAIT_RD, DONE.
  - IDLE: non-faulting memop in M -> o_dmem_req=1 combinationally; gnt=1 -> DONE (store) or WAIT_RD (load); gnt=0 -> REQ.
  - REQ: o_dmem_req=1, addr/we/be/wdata stable; on gnt as IDLE.
  - WAIT_RD: req=0; rvalid=1 -> latch i_dmem_rdata into load buffer, -> DONE. rvalid in same cycle as gnt is not legal.
  - DONE: req=0, stall=0; -> IDLE (next instruction enters M).
- o_stall = non-faulting memop & state!=DONE.
- RegWriteM = RegWrite_q & ~o_stall & ~o_mem_fault (prevents duplicate or bogus writes in MEM/WB, which has no enable).
- Store lanes: SB wdata={4{b}}, be=0001<<addr[1:0]; SH wdata={2{h}}, be=0011<<{addr[1],1'b0}; SW be=1111. Loads: be=1111.
- Load format: shift buffer right by 8*addr[1:0]; LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW pass. ReadDataM for non-loads: don't-care (0 acceptable).

## Timing
- Reset: all registered outputs 0, load buffer 0, state IDLE; o_dmem_req=0, o_stall=0, o_mem_fault=0. Reset mid-transaction abandons it; the memory side must tolerate the dropped request.
- Non-memop: zero stall; E->M in one cycle.
- Store, gnt on first cycle: exactly 1 stall cycle. Load, gnt first cycle and rvalid next: 2 stall cycles. Each cycle of gnt/rvalid wait adds one.
- Back-to-back memops: each starts from IDLE the cycle after DONE; no overlap, one outstanding access maximum.
- i_flush during stall ignored; in-flight access always completes.

## Test plan
- ALU op, RegWriteE=1, ALUResultE=0x1234, RdE=5 -> next cycle RegWriteM=1, ALUResultM=0x1234, RdM=5, o_stall=0, no req.
- SB addr 0x103, data 0xAB, gnt immediate -> req=1, we=1, addr 0x100, be=1000, wdata 0xABABABAB; stall 1 cycle; RegWriteM=0.
- LH addr 0x202, rdata 0x8001_0000, gnt after 2 cycles, rvalid 3 cycles later -> stall 6 cycles, ReadDataM=0xFFFF8001 in DONE, RegWriteM=1 exactly one cycle.
- LBU addr 0x3 on rdata 0x80xxxxxx -> 0x00000080; LW addr 0x6 -> o_mem_fault=1, no req, RegWriteM=0.
- i_flush during load wait -> ignored, load completes; i_rstn low in WAIT_RD -> all outputs 0, IDLE.
